// File: rtl/squat_pkg.sv
// squat_pkg: shared constants and types for the SQUAT Rx cell scheduler
package squat_pkg;
    localparam int CELL_BYTES = 53;
    localparam int NPORTS     = 4;
    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
    typedef logic [1:0] port_t;
    typedef logic [5:0] bidx_t;
    localparam bidx_t LAST_BYTE = bidx_t'(CELL_BYTES - 1);
endpackage

// File: rtl/squat_rr_arb.sv
// squat_rr_arb: 4-way combinational round-robin picker starting at ptr
module squat_rr_arb
    import squat_pkg::*;
(
    input  logic [3:0] req,
    input  port_t      ptr,
    output logic       gnt_vld,
    output port_t      gnt_idx
);
    // scan from the farthest offset down so the nearest request at or after ptr wins
    always_comb begin
        gnt_vld = |req;
        gnt_idx = ptr;
        for (int i = 3; i >= 0; i--)
            if (req[ptr + port_t'(i)]) gnt_idx = ptr + port_t'(i);
    end
endmodule

// File: rtl/squat_rx_sched.sv
// squat_rx_sched: polls the Utopia Rx ports round-robin and forwards granted cells to the ingress buffer
module squat_rx_sched
    import squat_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORTS-1:0]     Rx_clav,
    input  logic [NPORTS-1:0]     Rx_soc,
    input  logic [8*NPORTS-1:0]   Rx_data,
    output logic [NPORTS-1:0]     Rx_en,
    input  logic [NPORTS-1:0]     port_en,
    input  logic                  buf_space,
    output logic                  cell_vld,
    output logic [7:0]            cell_data,
    output logic                  cell_sop,
    output logic                  cell_eop,
    output port_t                 cell_port,
    output logic                  cell_err,
    output logic [7:0]            soc_err_cnt
);
    state_t     state, state_nxt;
    port_t      ptr, gnt, arb_idx;
    bidx_t      cnt, samp_k;
    logic       arb_vld, start, samp, abort, mid_err, last_en, cur_soc, err_flag;
    logic [7:0] cur_byte;

    squat_rr_arb u_arb (
        .req     (Rx_clav & port_en),
        .ptr     (ptr),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    // samp marks a cycle whose end samples byte samp_k of the granted port
    always_comb begin
        cur_soc   = Rx_soc[gnt];
        cur_byte  = Rx_data[{gnt, 3'b000} +: 8];
        start     = state == IDLE && buf_space && arb_vld;
        abort     = samp && samp_k == '0 && !cur_soc;
        mid_err   = samp && samp_k != '0 && cur_soc;
        last_en   = state == XFER && cnt == LAST_BYTE;
        state_nxt = state == IDLE ? (start ? XFER : IDLE) :
                    state == XFER ? (abort ? IDLE : last_en ? DRAIN : XFER) : IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // grant, enable sequencing, byte capture and SOC error tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Rx_en       <= '1;
            ptr         <= '0;
            gnt         <= '0;
            cnt         <= '0;
            samp        <= 1'b0;
            samp_k      <= '0;
            err_flag    <= 1'b0;
            soc_err_cnt <= '0;
            cell_vld    <= 1'b0;
            cell_data   <= '0;
            cell_sop    <= 1'b0;
            cell_eop    <= 1'b0;
            cell_port   <= '0;
            cell_err    <= 1'b0;
        end else begin
            Rx_en    <= start ? ~(NPORTS'(1) << arb_idx) : (abort || last_en) ? '1 : Rx_en;
            ptr      <= start ? port_t'(arb_idx + 2'd1) : ptr;
            gnt      <= start ? arb_idx : gnt;
            cnt      <= (state == XFER && state_nxt == XFER) ? cnt + 6'd1 : '0;
            samp     <= state == XFER && !abort;
            samp_k   <= cnt;
            err_flag <= start ? 1'b0 : err_flag || mid_err;
            if ((abort || mid_err) && soc_err_cnt != 8'hFF)
                soc_err_cnt <= soc_err_cnt + 8'd1;
            cell_vld <= samp && !abort;
            cell_sop <= samp && !abort && samp_k == '0;
            cell_eop <= samp && samp_k == LAST_BYTE;
            cell_err <= samp && samp_k == LAST_BYTE && (err_flag || mid_err);
            if (samp && !abort) begin
                cell_data <= cur_byte;
                cell_port <= gnt;
            end
        end
    end
endmodule

// File: tb/tb_squat_rx_sched.sv
// tb_squat_rx_sched: PHY model, transaction-level scheduler model and directed tests
module tb_squat_rx_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  Rx_clav = '0;
    logic [3:0]  Rx_soc = '0;
    logic [31:0] Rx_data = '0;
    logic [3:0]  Rx_en;
    logic [3:0]  port_en = 4'hF;
    logic        buf_space = 1'b1;
    logic        cell_vld, cell_sop, cell_eop, cell_err;
    logic [7:0]  cell_data, soc_err_cnt;
    logic [1:0]  cell_port;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    squat_rx_sched dut (
        .clk(clk), .rst(rst), .Rx_clav(Rx_clav), .Rx_soc(Rx_soc), .Rx_data(Rx_data),
        .Rx_en(Rx_en), .port_en(port_en), .buf_space(buf_space), .cell_vld(cell_vld),
        .cell_data(cell_data), .cell_sop(cell_sop), .cell_eop(cell_eop),
        .cell_port(cell_port), .cell_err(cell_err), .soc_err_cnt(soc_err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // PHY: per-port byte pointer; byte k = k + offs[p]; one-shot SOC faults
    logic [7:0] offs[4] = '{default: 8'h00};
    bit         inj_abort[4] = '{default: 1'b0};
    int         inj_mid[4] = '{default: -1};
    int         pos[4] = '{default: 0};
    logic [3:0] en_prev = 4'hF;

    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (!en_prev[p]) begin
                Rx_data[8*p +: 8] = 8'(pos[p]) + offs[p];
                Rx_soc[p] = (pos[p] == 0) ? !inj_abort[p] : (inj_mid[p] == pos[p]);
                if (pos[p] == 0) inj_abort[p] = 1'b0;
                else if (inj_mid[p] == pos[p]) inj_mid[p] = -1;
                pos[p]++;
            end else Rx_soc[p] = 1'b0;
            if (!Rx_en[p] && en_prev[p]) pos[p] = 0;
        end
        en_prev = Rx_en;
    end

    // scheduler model: decides grants from rules and books expected outputs per cycle
    typedef struct {logic [7:0] d; logic sop; logic eop; logic [1:0] port; logic err;} exp_t;
    logic [3:0] exp_en[int];
    exp_t       exp_b[int];
    bit         exp_inc[int];
    int         m_ptr = 0, m_free = 0, m_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_en.delete(); exp_b.delete(); exp_inc.delete();
            m_ptr = 0; m_free = 0; m_cnt = 0;
            chk("rst_rx_en", 32'(Rx_en), 32'hF);
            chk("rst_vld", 32'(cell_vld), 0);
            chk("rst_flags", {cell_sop, cell_eop, cell_err}, 0);
            chk("rst_data", 32'(cell_data), 0);
            chk("rst_port", 32'(cell_port), 0);
            chk("rst_err_cnt", 32'(soc_err_cnt), 0);
        end else begin
            if (exp_inc.exists(cyc)) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            chk("rx_en", 32'(Rx_en), 32'(exp_en.exists(cyc) ? exp_en[cyc] : 4'hF));
            chk("cell_vld", 32'(cell_vld), 32'(exp_b.exists(cyc)));
            if (exp_b.exists(cyc)) begin
                chk("cell_data", 32'(cell_data), 32'(exp_b[cyc].d));
                chk("cell_sop", 32'(cell_sop), 32'(exp_b[cyc].sop));
                chk("cell_eop", 32'(cell_eop), 32'(exp_b[cyc].eop));
                chk("cell_port", 32'(cell_port), 32'(exp_b[cyc].port));
                chk("cell_err", 32'(cell_err), 32'(exp_b[cyc].err));
            end
            chk("soc_err_cnt", 32'(soc_err_cnt), 32'(m_cnt));
            if (cyc >= m_free && buf_space && (Rx_clav & port_en) != 4'h0) begin
                int g, t, mid;
                logic [3:0] en_v;
                bit mid_ok;
                g = 0;
                for (int i = 3; i >= 0; i--)
                    if (Rx_clav[(m_ptr + i) % 4] && port_en[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
                m_ptr = (g + 1) % 4;
                en_v = 4'hF;
                en_v[g] = 1'b0;
                t = cyc + 1;
                mid = inj_mid[g];
                mid_ok = mid >= 1 && mid <= 52;
                if (inj_abort[g]) begin
                    exp_en[t] = en_v;
                    exp_en[t+1] = en_v;
                    exp_inc[t+2] = 1'b1;
                    m_free = t + 2;
                end else begin
                    for (int k = 0; k < 53; k++) begin
                        exp_en[t+k] = en_v;
                        exp_b[t+2+k] = '{d: 8'(k) + offs[g], sop: k == 0, eop: k == 52,
                                         port: 2'(g), err: mid_ok && k == 52};
                    end
                    if (mid_ok) exp_inc[t+2+mid] = 1'b1;
                    m_free = t + 54;
                end
            end
        end
    end

    // monitor: grant order/times, enable run lengths, and completed cells
    typedef struct {int n; logic [7:0] first; logic [7:0] last; logic [1:0] port; logic err;} cell_t;
    int         gq[$], gt[$], lq[$];
    cell_t      cells[$];
    cell_t      cur;
    bit         in_cell = 1'b0;
    int         run_len = 0;
    logic [3:0] mon_prev = 4'hF;

    always @(negedge clk) begin
        if (!rst) begin
            in_cell = 1'b0; run_len = 0; mon_prev = 4'hF;
        end else begin
            for (int p = 0; p < 4; p++)
                if (!Rx_en[p] && mon_prev[p]) begin
                    gq.push_back(p);
                    gt.push_back(cyc);
                end
            if (Rx_en != 4'hF) run_len++;
            else if (mon_prev != 4'hF) begin
                lq.push_back(run_len);
                run_len = 0;
            end
            if (cell_vld) begin
                if (cell_sop) begin
                    cur.n = 0; cur.first = cell_data; cur.port = cell_port; cur.err = 1'b0;
                    in_cell = 1'b1;
                end
                cur.n++;
                cur.last = cell_data;
                if (cell_eop && in_cell) begin
                    cur.err = cell_err;
                    cells.push_back(cur);
                    in_cell = 1'b0;
                end
            end
            mon_prev = Rx_en;
        end
    end

    task automatic clear_mon();
        gq.delete(); gt.delete(); lq.delete(); cells.delete();
    endtask

    initial begin
        #1 rst = 1'b0;
        run(3);
        rst = 1'b1;
        run(2);

        // all four ports continuously: 0,1,2,3,0 at 55-cycle spacing
        offs = '{8'h00, 8'h40, 8'h80, 8'hC0};
        clear_mon();
        Rx_clav = 4'hF;
        run(225);
        Rx_clav = 4'h0;
        run(60);
        chk("rr_count", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", gq[i], (i % 4));
        for (int i = 1; i < 5 && i < gt.size(); i++) chk("rr_spacing", gt[i] - gt[i-1], 55);

        // port 2 alone, bytes 0x00..0x34
        offs = '{default: 8'h00};
        clear_mon();
        Rx_clav = 4'b0100;
        run(3);
        Rx_clav = 4'h0;
        run(60);
        chk("p2_grants", gq.size(), 1);
        chk("p2_port", gq.size() > 0 ? gq[0] : -1, 2);
        chk("p2_en_len", lq.size() > 0 ? lq[0] : -1, 53);
        chk("p2_cells", cells.size(), 1);
        if (cells.size() > 0) begin
            chk("p2_nbytes", cells[0].n, 53);
            chk("p2_first", 32'(cells[0].first), 32'h00);
            chk("p2_last", 32'(cells[0].last), 32'h34);
            chk("p2_cell_port", 32'(cells[0].port), 2);
            chk("p2_err", 32'(cells[0].err), 0);
        end

        // port_en masks to ports 1 and 3
        offs = '{8'h00, 8'h40, 8'h80, 8'hC0};
        clear_mon();
        port_en = 4'b1010;
        Rx_clav = 4'hF;
        run(170);
        Rx_clav = 4'h0;
        port_en = 4'hF;
        run(60);
        chk("mask_count", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("mask_order", gq[i], (i % 2 == 0) ? 3 : 1);

        // byte-0 SOC missing on port 0: abort, then port 1
        clear_mon();
        inj_abort[0] = 1'b1;
        Rx_clav = 4'b0011;
        run(10);
        Rx_clav = 4'h0;
        run(60);
        chk("abort_port", gq.size() > 0 ? gq[0] : -1, 0);
        chk("abort_en_len", lq.size() > 0 ? lq[0] : -1, 2);
        chk("abort_next", gq.size() > 1 ? gq[1] : -1, 1);
        chk("abort_cnt", 32'(soc_err_cnt), 1);
        chk("abort_cells", cells.size(), 1);
        if (cells.size() > 0) chk("abort_cell_port", 32'(cells[0].port), 1);

        // stray SOC on byte 20 of port 2
        clear_mon();
        inj_mid[2] = 20;
        Rx_clav = 4'b0100;
        run(3);
        Rx_clav = 4'h0;
        run(60);
        chk("mid_cells", cells.size(), 1);
        if (cells.size() > 0) begin
            chk("mid_nbytes", cells[0].n, 53);
            chk("mid_err", 32'(cells[0].err), 1);
        end
        chk("mid_cnt", 32'(soc_err_cnt), 2);

        // no buffer space: no grant; then reset mid-cell
        clear_mon();
        buf_space = 1'b0;
        Rx_clav = 4'hF;
        run(20);
        chk("nobuf_grants", gq.size(), 0);
        buf_space = 1'b1;
        run(32);
        #2;
        chk("pre_rst_en", 32'(Rx_en), 32'h7);
        rst = 1'b0;
        #1;
        chk("async_rst_en", 32'(Rx_en), 32'hF);
        chk("async_rst_vld", 32'(cell_vld), 0);
        run(3);
        rst = 1'b1;
        clear_mon();
        run(5);
        Rx_clav = 4'h0;
        chk("post_rst_grant", gq.size() > 0 ? gq[0] : -1, 0);
        run(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/squat_rx_sched.md
# squat_rx_sched

Receive-side cell scheduler for the SQUAT ATM switch. It polls the four Level‑1 Utopia Rx PHY ports and grants one port at a time in round-robin order. It sequences the 53‑byte cell transfer on the granted port and forwards the bytes, tagged with the source port, to the shared ingress cell buffer. It sits between the Utopia Rx pins and the switch core, and is gated by the management port-enable register.

## Interface
Parameters:
- CELL_BYTES, 53, bytes per cell (UNI cell, no UDF).
- NPORTS, 4, number of Rx ports (fixed by the SQUAT pinout).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- Rx_clav  in  4  per-port cell-available from the PHY.
- Rx_soc  in  4  per-port start-of-cell.
- Rx_data  in  32  Rx_data[8p+7:8p] is port p.
- Rx_en  out  4  per-port enable, active-low (Utopia).
- port_en  in  4  management port-enable mask; 1 = port may be polled.
- buf_space  in  1  ingress buffer can accept one full cell.
- cell_vld  out  1  cell_data, cell_sop, cell_eop, cell_port and cell_err are valid.
- cell_data  out  8  cell byte.
- cell_sop  out  1  first byte (header byte 0).
- cell_eop  out  1  byte CELL_BYTES-1.
- cell_port  out  2  source port of the cell.
- cell_err  out  1  qualified by cell_eop; an unexpected SOC was seen mid-cell.
- soc_err_cnt  out  8  saturating count of SOC errors.

## Operation
- FSM states: IDLE, XFER, DRAIN.
- IDLE:
  - Eligible port: Rx_clav[p] & port_en[p].
  - When buf_space=1 and any port is eligible, grant the first eligible port starting at ptr.
  - Set ptr = grant+1 mod 4 and go to XFER.
- XFER:
  - Drive Rx_en[grant]=0 for exactly CELL_BYTES cycles.
  - Byte counter runs 0..CELL_BYTES-1.
  - Go to DRAIN after the last enable cycle.
- DRAIN: capture the final byte, then return to IDLE.
- SOC check on byte 0:
  - Rx_soc[grant]=0 is an abort: byte 0 is not forwarded and Rx_en returns high from the next cycle.
  - On abort, soc_err_cnt increments and the FSM goes to IDLE; ptr has already advanced.
- SOC check on bytes 1..52:
  - Rx_soc[grant]=1 sets a sticky error flag, and soc_err_cnt increments.
  - The cell still completes, with cell_err=1 on its eop byte.
- Ignored inputs mid-cell:
  - Rx_clav: cell-level handshake.
  - port_en changes: the current cell completes.
  - buf_space: it is only checked at grant.
- soc_err_cnt saturates at 255.
- Reset (asynchronous, also mid-cell):
  - Rx_en=4'hF immediately.
  - FSM goes to IDLE, ptr=0, byte counter=0, soc_err_cnt=0.
  - cell_vld, cell_sop, cell_eop, cell_err = 0; cell_data=0, cell_port=0.
  - A partially transferred cell is discarded; the buffer handles a missing eop.

## Timing
- Let cycle t be the first cycle with Rx_en[g]=0.
  - The grant was decided in IDLE at t-1, and Rx_en is registered.
- Rx_en[g]=0 for cycles t..t+52.
- The PHY presents byte k in cycle t+1+k, and it is sampled at the end of that cycle.
- cell_vld=1 for cycles t+2..t+54, one byte per cycle with no gaps.
  - cell_sop is set at t+2 and cell_eop at t+54.
- DRAIN occurs at t+53 and IDLE at t+54.
  - The earliest next Rx_en=0 is t+55, so the minimum cell period is 55 cycles.
- SOC abort: Rx_en[g]=0 only in cycles t and t+1, with no cell_vld.
  - soc_err_cnt is updated at t+2, and the FSM is back in IDLE at t+2.
- At most one Rx_en bit is low at any time.
- cell_port is constant from sop to eop.

## Structure
- Package squat_pkg holds:
  - CELL_BYTES and NPORTS.
  - The state enum {IDLE, XFER, DRAIN}.
  - The port-index typedef (2 bits).
- Sub-module squat_rr_arb: a 4-way combinational round-robin picker.
  - Inputs: req[3:0] and ptr[1:0].
  - Outputs: gnt_vld and gnt_idx[1:0].
  - It is shared with the future Tx scheduler.

## Test plan
- Port 2 only, clav=1, port_en=4'hF, buf_space=1:
  - Rx_en[2] is low for 53 cycles.
  - 53 bytes 0x00..0x34 arrive with cell_port=2, sop on 0x00 and eop on 0x34, and cell_err=0.
- All four ports with clav=1, continuously:
  - Grants come in order 0,1,2,3,0 with cell starts 55 cycles apart.
- port_en=4'b1010 with all clav=1: only ports 1 and 3 are granted, alternating.
- Port 0 byte 0 has soc=0:
  - Rx_en[0] is low for 2 cycles, no cell_vld, soc_err_cnt=1.
  - The next grant goes to port 1.
- soc=1 on byte 20: all 53 bytes are forwarded, cell_err=1 at eop, soc_err_cnt increments by 1.
- buf_space=0 with clav=1: no grant. Then rst=0 asserted at byte 30:
  - Rx_en=4'hF and cell_vld=0 immediately.
  - After reset release, the first grant is port 0.
